// File: rtl/cw_issue_sequencer_if.sv
// Control-signal port into the datapath control register.
// The sequencer drives cw through the write modport; the datapath reads it through the read modport.
interface Control_signals_if #(
  parameter int CW_W = 16
);
  logic [CW_W-1:0] cw;

  modport write (output cw);
  modport read  (input  cw);
endinterface

// File: rtl/cw_issue_sequencer.sv
// Issue sequencer: buffers up to two decoded control words and issues at most one per cycle.
// It inserts NOP cycles after multi-cycle words, while hold is high, and after a flush.
//
// Handshake: a word transfers on the rising edge where dec_valid & dec_ready are both high.
// dec_ready is a function of registered occupancy plus flush/reset only, so it never depends on
// dec_valid. Once issued, a word appears on ctrl.cw for exactly one cycle, qualified by issue_valid.
module cw_issue_sequencer #(
  parameter int LAT_W = 4,
  parameter int CW_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [CW_W-1:0]  dec_cw,
  input  logic [LAT_W-1:0] dec_lat,
  input  logic             hold,
  input  logic             flush,
  Control_signals_if.write ctrl,
  output logic             issue_valid,
  output logic             busy,
  output logic             dbg_wait
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CW_W-1:0]  buf_cw_q  [2];
  logic [LAT_W-1:0] buf_lat_q [2];
  logic [LAT_W-1:0] wait_q, wait_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic             iv_q, iv_d;
  logic             push, pop;

  assign dec_ready   = (count_q != 2'd2) & ~flush & ~reset;
  assign push        = dec_valid & dec_ready;
  assign busy        = (count_q != 2'd0) | (state_q == WAIT);
  assign issue_valid = iv_q;
  assign ctrl.cw     = cw_q;
  assign dbg_wait    = (state_q == WAIT);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cw_d     = '0;
    iv_d     = 1'b0;
    pop      = 1'b0;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (state_q == IDLE) begin
      if (count_q != 2'd0 && !hold) begin
        pop  = 1'b1;
        cw_d = buf_cw_q[rd_ptr_q];
        iv_d = 1'b1;
        if (buf_lat_q[rd_ptr_q] != '0) begin
          wait_d  = buf_lat_q[rd_ptr_q];
          state_d = WAIT;
        end
      end
    end else begin
      // The wait counter runs down regardless of hold.
      if (wait_q <= LAT_W'(1)) begin
        wait_d  = '0;
        state_d = IDLE;
      end else begin
        wait_d = wait_q - LAT_W'(1);
      end
    end

    if (flush) begin
      state_d = IDLE;
      wait_d  = '0;
      cw_d    = '0;
      iv_d    = 1'b0;
      pop     = 1'b0;
    end

    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      cw_q     <= '0;
      iv_q     <= 1'b0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cw_q     <= cw_d;
      iv_q     <= iv_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset; count_q alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_cw_q[wr_ptr_q]  <= dec_cw;
      buf_lat_q[wr_ptr_q] <= dec_lat;
    end
  end

endmodule

// File: tb/tb_cw_issue_sequencer.sv
// Randomized bench for cw_issue_sequencer, checked against a queue-and-earliest-issue-cycle model.
// Each issued word is expected at a specific cycle; a negedge monitor checks outputs every cycle.
module tb_cw_issue_sequencer;
  localparam int LAT_W = 4;
  localparam int CW_W  = 16;
  localparam int N_CYC = 4000;

  logic             clk = 1'b0;
  logic             reset, dec_valid, hold, flush;
  logic             dec_ready, issue_valid, busy, dbg_wait;
  logic [CW_W-1:0]  dec_cw;
  logic [LAT_W-1:0] dec_lat;

  Control_signals_if #(.CW_W(CW_W)) ctrl_if ();

  cw_issue_sequencer #(.LAT_W(LAT_W), .CW_W(CW_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_cw     (dec_cw),
    .dec_lat    (dec_lat),
    .hold       (hold),
    .flush      (flush),
    .ctrl       (ctrl_if),
    .issue_valid(issue_valid),
    .busy       (busy),
    .dbg_wait   (dbg_wait)
  );

  always #5 clk = ~clk;

  // Reference model: buffered words in order, plus the earliest edge at which the next issue may occur.
  logic [CW_W+LAT_W-1:0] mq[$];
  logic [CW_W+31:0]      exp_q[$];
  int                    n_ok;
  int                    cyc;
  int                    hold_pct;
  logic                  exp_ready, exp_busy;
  bit                    chk_en = 1'b0;
  bit                    quiet  = 1'b0;
  int                    vectors = 0;
  int                    miscompares = 0;

  task automatic model_edge();
    int pre;
    logic [CW_W+LAT_W-1:0] h;
    pre = mq.size();
    if (reset || flush) begin
      mq.delete();
      n_ok = cyc + 1;
    end else begin
      if (pre > 0 && !hold && cyc >= n_ok) begin
        h = mq.pop_front();
        exp_q.push_back({h[CW_W+LAT_W-1:LAT_W], 32'(cyc + 1)});
        n_ok = cyc + 1 + int'(h[LAT_W-1:0]);
      end
      if (dec_valid && pre < 2) mq.push_back({dec_cw, dec_lat});
    end
  endtask

  task automatic drive_cycle();
    if (cyc % 200 == 0) begin
      case ($urandom_range(0, 2))
        0:       hold_pct = 0;
        1:       hold_pct = 25;
        default: hold_pct = 70;
      endcase
    end
    if (quiet) begin
      reset = 1'b0; flush = 1'b0; hold = 1'b0; dec_valid = 1'b0;
      dec_cw = '0;  dec_lat = '0;
    end else begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      hold      = ($urandom_range(0, 99) < hold_pct);
      dec_valid = ($urandom_range(0, 9) < 7);
      dec_cw    = CW_W'($urandom);
      dec_lat   = ($urandom_range(0, 3) == 0) ? LAT_W'($urandom_range(1, 15)) : '0;
    end
    exp_ready = (mq.size() < 2) && !flush && !reset;
    exp_busy  = (mq.size() != 0) || (cyc < n_ok);
  endtask

  always @(negedge clk) begin
    logic [CW_W+31:0] e;
    if (chk_en) begin
      vectors++;
      if (dec_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL dec_ready cyc=%0d got=%b exp=%b", cyc, dec_ready, exp_ready);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      if (issue_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_issue cyc=%0d got_cw=%h exp=none", cyc, ctrl_if.cw);
        end else begin
          e = exp_q.pop_front();
          if (ctrl_if.cw !== e[CW_W+31:32] || int'(e[31:0]) != cyc) begin
            miscompares++;
            $display("FAIL issue cyc=%0d got_cw=%h exp_cw=%h exp_cyc=%0d",
                     cyc, ctrl_if.cw, e[CW_W+31:32], int'(e[31:0]));
          end
        end
      end else begin
        vectors++;
        if (issue_valid !== 1'b0 || ctrl_if.cw !== '0) begin
          miscompares++;
          $display("FAIL nop cyc=%0d got_iv=%b got_cw=%h exp_iv=0 exp_cw=0", cyc, issue_valid, ctrl_if.cw);
        end
        if (exp_q.size() > 0) begin
          vectors++;
          if (int'(exp_q[0][31:0]) <= cyc) begin
            e = exp_q.pop_front();
            miscompares++;
            $display("FAIL missing_issue cyc=%0d got_iv=0 exp_cw=%h exp_cyc=%0d",
                     cyc, e[CW_W+31:32], int'(e[31:0]));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0; dec_valid = 1'b0;
    dec_cw = '0;  dec_lat = '0; hold_pct = 0;
    @(posedge clk);
    #1;
    cyc  = 1;
    n_ok = 0;
    mq.delete();
    exp_q.delete();
    drive_cycle();
    chk_en = 1'b1;
    repeat (N_CYC) begin
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      drive_cycle();
    end
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      drive_cycle();
    end
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got_pending=%0d exp_pending=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
